serial_tx_queue: RTL and testbench
==================================

# serial_tx_queue

Byte FIFO that sits directly upstream of the UART transmitter and decouples bursty byte writes (e.g. from the core's MMIO store path) from the serial line rate. It accepts single-cycle byte writes, buffers up to DEPTH bytes, and presents them one at a time on a valid/ready pair matching the transmitter's `tx_data` / `tx_data_available` / `tx_ready` handshake. It also reports fill level and a sticky overflow flag.

## Interface
- `DEPTH`, default 16: FIFO capacity in bytes. Must be a power of two, ≥ 2.
- `clock`  input  1: sole clock; all state updates on rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `write_data`  input  8: byte to enqueue.
- `write_enable`  input  1: enqueue request, sampled each rising edge.
- `write_ready`  output  1: high when FIFO is not full.
- `overflow_clear`  input  1: clears the sticky overflow flag.
- `overflow`  output  1: sticky; set when a write is dropped.
- `fifo_count`  output  $clog2(DEPTH)+1: bytes currently stored, 0..DEPTH.
- `tx_data`  output  8: byte offered to the transmitter.
- `tx_data_available`  output  1: `tx_data` is valid.
- `tx_ready`  input  1: transmitter idle; accepts `tx_data` on an edge where both this and `tx_data_available` are high.

## Operation
- Storage: DEPTH×8 register array, read pointer, write pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), and count register. Full = count==DEPTH; empty = count==0.
- Push: on an edge with `write_enable` and `write_ready`, store `write_data` at write pointer, advance it.
- Dropped write: `write_enable` while full → data discarded, pointers/count unchanged, `overflow` set. Full is evaluated before any same-cycle pop; a write while full is dropped even if a pop occurs that cycle.
- Pop ("transfer"): edge with `tx_data_available && tx_ready` and the current head fully sent (see Configuration); read pointer advances.
- Count: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- `tx_data` = array entry at read pointer (combinational read, or 0x0D per Configuration). `tx_data_available` = !empty.
- No bypass: a byte written into an empty FIFO is not visible on `tx_data` until the following cycle.
- `overflow_clear` clears `overflow`; if a drop occurs in the same cycle, set wins.

## Timing
- Reset: `fifo_count`=0, `tx_data_available`=0, `write_ready`=1, `overflow`=0, pointers 0, CR-state cleared. `tx_data` don't-care while unavailable. Reset mid-operation discards all buffered bytes, including a pending CR/LF pair; reset overrides all other inputs in that cycle.
- Write at edge N into empty FIFO → `tx_data_available` high after edge N; earliest transfer at edge N+1.
- Fill 1→0 on transfer at edge N → `tx_data_available` low after edge N.
- `write_ready` falls the cycle after the push that makes count==DEPTH; rises the cycle after the pop from full.
- Throughput: one push and one pop per cycle max; sustained output limited by transmitter (one byte per 10 bit times).

## Configuration
- Macro `SERIAL_TX_QUEUE_CRLF_EN`.
- Defined: head byte 0x0A is emitted as the pair 0x0D, 0x0A. Internal flag `cr_sent` (reset 0). When head==0x0A and `cr_sent`=0, `tx_data`=0x0D; a transfer sets `cr_sent`=1 without popping. Next offer is 0x0A; its transfer pops and clears `cr_sent`. `fifo_count` counts stored bytes only (the LF counts as one). All other bytes unchanged.
- Undefined: bytes pass verbatim; no `cr_sent` logic exists.

## Test plan
- Reset then idle: `tx_data_available`=0, `fifo_count`=0, `write_ready`=1, `overflow`=0 for 10 cycles.
- Write 0x41,0x42,0x43 on consecutive cycles with `tx_ready`=0 → count 3; then `tx_ready`=1 one cycle at a time → 0x41,0x42,0x43 transferred in order, count returns to 0, `tx_data_available` low.
- Fill 16 bytes, write 0x55 with `tx_ready`=0 → `write_ready`=0, `overflow`=1, count 16, 0x55 never emitted; `overflow_clear` → `overflow`=0 next cycle.
- Simultaneous push and pop at count 5 → count stays 5; wrap-around: push/pop 40 bytes through DEPTH=16, output sequence equals input.
- With `SERIAL_TX_QUEUE_CRLF_EN`: write 0x48,0x0A → transmitter receives 0x48,0x0D,0x0A; count drops 2→1 after 0x48, stays 1 after 0x0D, 0 after 0x0A. Without macro: receives 0x48,0x0A.
- Assert reset after 0x0D sent with 0x0A pending → count 0, `tx_data_available`=0; next written 0x0A emits 0x0D first again.

Source files
------------

// File: rtl/serial_tx_queue.sv
// serial_tx_queue: byte FIFO buffering bursty writes ahead of the UART transmitter.
// Latency: a byte written into an empty queue is offered on tx_data one cycle later.
// Backpressure: write_ready low when full (writes then dropped, sticky overflow); output held until tx_ready.
// Optional: define SERIAL_TX_QUEUE_CRLF_EN to expand each stored 0x0A into the pair 0x0D, 0x0A.
module serial_tx_queue #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               write_data,
  input  logic                     write_enable,
  output logic                     write_ready,
  input  logic                     overflow_clear,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               tx_data,
  output logic                     tx_data_available,
  input  logic                     tx_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          xfer;
  logic          pop;
  logic [7:0]    head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a write while full is dropped
  // even when a pop frees a slot in the same cycle.
  assign push = write_enable && !full;
  assign drop = write_enable && full;
  assign xfer = tx_data_available && tx_ready;

`ifdef SERIAL_TX_QUEUE_CRLF_EN
  logic cr_sent_q, cr_sent_d;
  logic head_is_lf;

  assign head_is_lf = (head == 8'h0A);
  // An LF at the head is first offered as CR; only the second transfer retires it.
  assign pop        = xfer && (!head_is_lf || cr_sent_q);
  assign tx_data    = (head_is_lf && !cr_sent_q) ? 8'h0D : head;

  // Track whether the CR for the LF at the head has already gone out.
  always_comb begin
    cr_sent_d = cr_sent_q;
    if (xfer && head_is_lf && !cr_sent_q) begin
      cr_sent_d = 1'b1;
    end else if (pop) begin
      cr_sent_d = 1'b0;
    end
  end

  // CR-state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cr_sent_q <= 1'b0;
    end else begin
      cr_sent_q <= cr_sent_d;
    end
  end
`else
  assign pop     = xfer;
  assign tx_data = head;
`endif

  assign tx_data_available = !empty;
  assign write_ready       = !full;
  assign overflow          = overflow_q;
  assign fifo_count        = count_q;

  // Next-state for pointers, fill count and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  // Control registers; reset discards everything buffered.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_serial_tx_queue.sv
// Scoreboard bench for serial_tx_queue: stimulus queues expected bytes,
// a monitor compares each byte accepted by the transmitter side.
module tb_serial_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    write_data = 8'h00;
  logic          write_enable = 1'b0;
  logic          write_ready;
  logic          overflow_clear = 1'b0;
  logic          overflow;
  logic [CW-1:0] fifo_count;
  logic [7:0]    tx_data;
  logic          tx_data_available;
  logic          tx_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  serial_tx_queue #(.DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .write_data        (write_data),
    .write_enable      (write_enable),
    .write_ready       (write_ready),
    .overflow_clear    (overflow_clear),
    .overflow          (overflow),
    .fifo_count        (fifo_count),
    .tx_data           (tx_data),
    .tx_data_available (tx_data_available),
    .tx_ready          (tx_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Record what the transmitter should see for one accepted byte.
  task automatic push_exp(input logic [7:0] b);
`ifdef SERIAL_TX_QUEUE_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  // Single-cycle write; expected only if the bench knows it is accepted.
  task automatic wr(input logic [7:0] b, input bit accepted);
    write_data   = b;
    write_enable = 1'b1;
    if (accepted) push_exp(b);
    step();
    write_enable = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while ((fifo_count != 0 || tx_data_available) && n < 200) begin
      step();
      n++;
    end
    tx_ready = 1'b0;
    chk({name, "_drain_done"}, int'(n < 200), 1);
    chk({name, "_count0"}, int'(fifo_count), 0);
    chk({name, "_avail0"}, int'(tx_data_available), 0);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both
  // handshake signals are high at the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && tx_data_available && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tx", int'(tx_data), -1);
        end else begin
          chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    step();
    step();
    reset = 1'b0;

    // Reset and idle.
    for (int i = 0; i < 10; i++) begin
      chk("idle_avail", int'(tx_data_available), 0);
      chk("idle_count", int'(fifo_count), 0);
      chk("idle_wrdy", int'(write_ready), 1);
      chk("idle_ovf", int'(overflow), 0);
      step();
    end

    // Three bytes, then released one at a time.
    wr(8'h41, 1'b1);
    chk("no_bypass_avail", int'(tx_data_available), 1);
    wr(8'h42, 1'b1);
    wr(8'h43, 1'b1);
    chk("abc_count3", int'(fifo_count), 3);
    pulse_tx();
    chk("abc_count2", int'(fifo_count), 2);
    step();
    pulse_tx();
    chk("abc_count1", int'(fifo_count), 1);
    pulse_tx();
    chk("abc_count0", int'(fifo_count), 0);
    chk("abc_avail0", int'(tx_data_available), 0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_wrdy", int'(write_ready), 1);
      wr(8'h10 + 8'(i), 1'b1);
    end
    chk("full_count", int'(fifo_count), DEPTH);
    chk("full_wrdy", int'(write_ready), 0);
    chk("full_ovf_before", int'(overflow), 0);
    wr(8'h55, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(fifo_count), DEPTH);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    // Clear and drop together: the drop wins.
    overflow_clear = 1'b1;
    wr(8'h55, 1'b0);
    overflow_clear = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    // Write while full with a pop in the same cycle is still dropped.
    tx_ready = 1'b1;
    wr(8'h56, 1'b0);
    tx_ready = 1'b0;
    chk("pop_from_full_count", int'(fifo_count), DEPTH - 1);
    chk("pop_from_full_wrdy", int'(write_ready), 1);
    drain("full");
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1'b1);
    chk("pp_count5", int'(fifo_count), 5);
    tx_ready = 1'b1;
    wr(8'h65, 1'b1);
    tx_ready = 1'b0;
    chk("pp_count_still5", int'(fifo_count), 5);
    drain("pp");

    // Wrap-around: 40 bytes streamed with the transmitter always ready.
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) wr(8'h80 + 8'(i), 1'b1);
    tx_ready = 1'b1;
    drain("wrap");
    chk("wrap_all_seen", exp_q.size(), 0);

    // LF handling.
    wr(8'h48, 1'b1);
    wr(8'h0A, 1'b1);
    chk("lf_count2", int'(fifo_count), 2);
    pulse_tx();
    chk("lf_after_h", int'(fifo_count), 1);
    pulse_tx();
`ifdef SERIAL_TX_QUEUE_CRLF_EN
    chk("lf_after_cr", int'(fifo_count), 1);
    chk("lf_after_cr_avail", int'(tx_data_available), 1);
    pulse_tx();
`endif
    chk("lf_after_lf", int'(fifo_count), 0);
    chk("lf_avail0", int'(tx_data_available), 0);

    // Reset with bytes pending (after the CR went out in the CRLF build).
    wr(8'h0A, 1'b1);
    wr(8'h41, 1'b1);
    pulse_tx();
    reset        = 1'b1;
    write_data   = 8'h77;
    write_enable = 1'b1;
    step();
    reset        = 1'b0;
    write_enable = 1'b0;
    exp_q.delete();
    chk("rst_count0", int'(fifo_count), 0);
    chk("rst_avail0", int'(tx_data_available), 0);
    chk("rst_wrdy", int'(write_ready), 1);
    wr(8'h0A, 1'b1);
    chk("post_rst_count1", int'(fifo_count), 1);
    drain("post_rst");
    chk("final_all_seen", exp_q.size(), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
